// File: rtl/crc32_frame_ctrl_pkg.sv
// Shared types and constants for the CRC-32 frame controller and its byte serializer.
package crc32_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [31:0] CRC32_POLY            = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT_DEFAULT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE_DEFAULT = 32'hC704_DD7B;
  localparam int unsigned BYTE_CNT_W            = 16;

  // Transmit FCS: bit-reversed, inverted register.
  function automatic logic [31:0] crc32_fcs(input logic [31:0] crc);
    logic [31:0] fcs;
    for (int unsigned i = 0; i < 32; i++) fcs[i] = ~crc[31-i];
    return fcs;
  endfunction

endpackage

// File: rtl/crc32_byte_ser.sv
// Byte latch, bit counter and LSB-first serializer feeding the CRC register.
module crc32_byte_ser (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic       last_o,
  output logic       done_o
);

  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    byte_d = byte_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      byte_d = data_i;
      last_d = last_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      byte_d = {1'b0, byte_q[7:1]};
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      byte_q <= byte_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o  = byte_q[0];
  assign last_o = last_q;
  assign done_o = (cnt_q == 3'd7);

endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame-level CRC-32 engine: one bit per cycle, FCS/raw/residue-match results per frame.
module crc32_frame_ctrl
  import crc32_frame_ctrl_pkg::*;
#(
  parameter logic [31:0] INIT_VALUE = CRC32_INIT_DEFAULT,
  parameter logic [31:0] RESIDUE    = CRC32_RESIDUE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [7:0]            DATA_IN,
  input  logic                  DATA_VALID,
  input  logic                  DATA_LAST,
  output logic                  DATA_READY,
  input  logic                  ABORT,
  output logic                  BUSY,
  output logic                  CRC_VALID,
  output logic [31:0]           CRC_VALUE,
  output logic [31:0]           CRC_RAW,
  output logic                  CRC_MATCH,
  output logic [BYTE_CNT_W-1:0] BYTE_COUNT
);

  state_e                state_q, state_d;
  logic [31:0]           crc_q, crc_d, raw_q, raw_d, fcs_q, fcs_d;
  logic                  match_q, match_d, busy_q, busy_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  accept, shift_en, fb;
  logic                  ser_bit, ser_last, ser_done;

  assign DATA_READY = (state_q == IDLE) & ~ABORT;
  assign accept     = DATA_READY & DATA_VALID;
  assign shift_en   = (state_q == SHIFT) & ~ABORT;
  assign fb         = crc_q[31] ^ ser_bit;

  crc32_byte_ser u_ser (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .load_i (accept),
    .data_i (DATA_IN),
    .last_i (DATA_LAST),
    .shift_i(shift_en),
    .bit_o  (ser_bit),
    .last_o (ser_last),
    .done_o (ser_done)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    raw_d   = raw_q;
    fcs_d   = fcs_q;
    match_d = match_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          if (!busy_q) begin
            crc_d = INIT_VALUE;
            cnt_d = BYTE_CNT_W'(1);
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        crc_d = {crc_q[30:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
        if (ser_done) begin
          state_d = ser_last ? FINISH : IDLE;
          // Results are captured on entry to FINISH so they are already valid during it.
          if (ser_last) begin
            raw_d   = crc_d;
            fcs_d   = crc32_fcs(crc_d);
            match_d = (crc_d == RESIDUE);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (ABORT) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      crc_d   = crc_q;
      raw_d   = raw_q;
      fcs_d   = fcs_q;
      match_d = match_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      crc_q   <= INIT_VALUE;
      raw_q   <= '0;
      fcs_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      raw_q   <= raw_d;
      fcs_q   <= fcs_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY       = busy_q;
  assign CRC_VALID  = (state_q == FINISH) & ~ABORT;
  assign CRC_VALUE  = fcs_q;
  assign CRC_RAW    = raw_q;
  assign CRC_MATCH  = match_q;
  assign BYTE_COUNT = cnt_q;

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Scoreboard bench for crc32_frame_ctrl: reflected-table-free CRC-32 reference model, directed and random frames.
module tb_crc32_frame_ctrl;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0]     fcs;
    logic [31:0]     raw;
    logic            match;
    logic [15:0]     cnt;
    longint unsigned cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [7:0]  DATA_IN;
  logic        DATA_VALID;
  logic        DATA_LAST;
  logic        DATA_READY;
  logic        ABORT;
  logic        BUSY;
  logic        CRC_VALID;
  logic [31:0] CRC_VALUE;
  logic [31:0] CRC_RAW;
  logic        CRC_MATCH;
  logic [15:0] BYTE_COUNT;

  int unsigned     checks = 0;
  int unsigned     errors = 0;
  longint unsigned cyc = 0;
  longint unsigned acc_cyc = 0;
  exp_t            sb[$];

  crc32_frame_ctrl #(
    .INIT_VALUE(32'hFFFF_FFFF),
    .RESIDUE   (32'hC704_DD7B)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .DATA_IN   (DATA_IN),
    .DATA_VALID(DATA_VALID),
    .DATA_LAST (DATA_LAST),
    .DATA_READY(DATA_READY),
    .ABORT     (ABORT),
    .BUSY      (BUSY),
    .CRC_VALID (CRC_VALID),
    .CRC_VALUE (CRC_VALUE),
    .CRC_RAW   (CRC_RAW),
    .CRC_MATCH (CRC_MATCH),
    .BYTE_COUNT(BYTE_COUNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: standard reflected CRC-32 (poly 0xEDB88320), init all-ones.
  function automatic logic [31:0] ref_reflected(input byte_q_t d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[k]) begin
      c = c ^ {24'h0, d[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic exp_t make_exp(input byte_q_t d);
    exp_t e;
    logic [31:0] c;
    c = ref_reflected(d);
    e.fcs = ~c;
    for (int i = 0; i < 32; i++) e.raw[i] = c[31-i];
    e.match = (e.raw == 32'hC704_DD7B);
    e.cnt = (d.size() > 65535) ? 16'hFFFF : 16'(d.size());
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (RSTn === 1'b1 && CRC_VALID === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_crc_valid", 32'(CRC_VALID), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("crc_value", CRC_VALUE, e.fcs);
        chk("crc_raw", CRC_RAW, e.raw);
        chk("crc_match", 32'(CRC_MATCH), 32'(e.match));
        chk("byte_count", 32'(BYTE_COUNT), 32'(e.cnt));
        chk("valid_latency", 32'(cyc - e.cyc), 32'd9);
        chk("busy_in_finish", 32'(BUSY), 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int unsigned n;
    bit ok;
    n = 0;
    ok = 0;
    DATA_IN = b;
    DATA_LAST = last;
    DATA_VALID = 1'b1;
    while (n < 40) begin
      @(negedge CLK);
      if (DATA_READY === 1'b1) begin
        acc_cyc = cyc;
        @(posedge CLK);
        #1;
        ok = 1;
        break;
      end
      n++;
    end
    DATA_VALID = 1'b0;
    DATA_LAST = 1'b0;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input byte_q_t d, input int abort_idx, input int unsigned max_gap);
    exp_t e;
    for (int i = 0; i < d.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge CLK);
        #1;
      end
      send_byte(d[i], (i == d.size() - 1));
      if (i == abort_idx) begin
        repeat (3) @(posedge CLK);
        #1;
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        @(negedge CLK);
        chk("busy_after_abort", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        return;
      end
    end
    e = make_exp(d);
    e.cyc = acc_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) chk("crc_valid_timeout", 32'(sb.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_valid"}, 32'(CRC_VALID), 32'd0);
    chk({tag, "_value"}, CRC_VALUE, 32'd0);
    chk({tag, "_raw"}, CRC_RAW, 32'd0);
    chk({tag, "_match"}, 32'(CRC_MATCH), 32'd0);
    chk({tag, "_count"}, 32'(BYTE_COUNT), 32'd0);
    chk({tag, "_ready"}, 32'(DATA_READY), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    byte_q_t s123, f, t;
    logic [15:0] cnt_before;
    logic [31:0] c;

    RSTn = 1'b0;
    ABORT = 1'b0;
    DATA_VALID = 1'b0;
    DATA_LAST = 1'b0;
    DATA_IN = 8'h00;
    s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    #2;
    check_reset_outputs("rst");
    #10 RSTn = 1'b1;
    @(posedge CLK);
    #1;

    send_frame(s123, -1, 0);
    wait_idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("hold_123_value", CRC_VALUE, 32'hCBF4_3926);
    chk("hold_123_count", 32'(BYTE_COUNT), 32'd9);
    chk("hold_busy", 32'(BUSY), 32'd0);

    f = '{8'h00};
    send_frame(f, -1, 0);
    wait_idle();
    chk("single_zero_value", CRC_VALUE, 32'hD202_EF8D);
    chk("single_zero_count", 32'(BYTE_COUNT), 32'd1);

    f = s123;
    f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    send_frame(f, -1, 1);
    wait_idle();
    chk("residue_raw", CRC_RAW, 32'hC704_DD7B);
    chk("residue_match", 32'(CRC_MATCH), 32'd1);
    f[f.size() - 1] = 8'hCA;
    send_frame(f, -1, 0);
    wait_idle();
    chk("bad_fcs_match", 32'(CRC_MATCH), 32'd0);

    send_frame(s123, 2, 0);
    send_frame(s123, -1, 0);
    wait_idle();
    chk("after_abort_value", CRC_VALUE, 32'hCBF4_3926);

    cnt_before = BYTE_COUNT;
    ABORT = 1'b1;
    DATA_VALID = 1'b1;
    DATA_IN = 8'h55;
    DATA_LAST = 1'b1;
    @(negedge CLK);
    chk("abort_idle_ready", 32'(DATA_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("abort_idle_busy", 32'(BUSY), 32'd0);
    chk("abort_idle_count", 32'(BYTE_COUNT), 32'(cnt_before));
    ABORT = 1'b0;
    DATA_VALID = 1'b0;
    DATA_LAST = 1'b0;

    for (int i = 0; i < 4; i++) send_byte(s123[i], 1'b0);
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    send_frame(s123, -1, 0);
    wait_idle();
    chk("after_reset_value", CRC_VALUE, 32'hCBF4_3926);

    send_frame(s123, -1, 0);
    f = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(f, -1, 0);
    wait_idle();

    for (int n = 0; n < 16; n++) begin
      t.delete();
      repeat ($urandom_range(20, 1)) t.push_back(8'($urandom));
      if (n % 4 == 3) begin
        c = ~ref_reflected(t);
        for (int k = 0; k < 4; k++) t.push_back(c[8*k +: 8]);
      end
      send_frame(t, -1, (n % 2 == 0) ? 0 : 2);
    end
    wait_idle();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc32_frame_ctrl.md
CRC32_FRAME_CTRL -- requirements
Module: crc32_frame_ctrl

Interface
REQ-001 SHALL have parameter INIT_VALUE, default 32'hFFFF_FFFF: CRC register preset loaded at frame start.
REQ-002 SHALL have parameter RESIDUE, default 32'hC704_DD7B: raw register value meaning a good frame when the received FCS is included.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DATA_IN  input  8  frame byte.
REQ-006 SHALL have port DATA_VALID  input  1  DATA_IN/DATA_LAST valid.
REQ-007 SHALL have port DATA_LAST  input  1  current byte ends the frame.
REQ-008 SHALL have port DATA_READY  output  1  byte accepted when DATA_VALID & DATA_READY.
REQ-009 SHALL have port ABORT  input  1  discard the current frame.
REQ-010 SHALL have port BUSY  output  1  frame in progress (at least one byte accepted, no CRC_VALID yet).
REQ-011 SHALL have port CRC_VALID  output  1  one-cycle pulse: the result outputs are valid.
REQ-012 SHALL have port CRC_VALUE  output  32  transmit FCS: CRC_VALUE[i] = ~crc_reg[31-i].
REQ-013 SHALL have port CRC_RAW  output  32  final CRC register, unmodified.
REQ-014 SHALL have port CRC_MATCH  output  1  crc_reg == RESIDUE; qualified by CRC_VALID.
REQ-015 SHALL have port BYTE_COUNT  output  16  bytes accepted in the current or last frame; saturates at 16'hFFFF.

Function
REQ-016 SHALL implement CRC-32 with polynomial 0x04C11DB7. The register shifts toward bit 31; feedback = crc_reg[31] ^ bit; one bit per enabled cycle.
REQ-017 SHALL serialize each byte LSB first (DATA_IN[0] first).
REQ-018 SHALL use FSM states IDLE, SHIFT and FINISH; reset state is IDLE.
REQ-019 IDLE: DATA_READY = ~ABORT. On accept, SHALL latch the byte and DATA_LAST, clear the bit counter, and go to SHIFT.
REQ-020 On accept with BUSY=0 (first byte), SHALL load crc_reg with INIT_VALUE on that edge, set BUSY, and set BYTE_COUNT to 1. Otherwise BYTE_COUNT SHALL increment, saturating.
REQ-021 SHIFT: SHALL shift one bit per cycle for exactly 8 cycles with DATA_READY=0. After bit 7: go to FINISH if the latched LAST flag is set, else go to IDLE.
REQ-022 Throughput SHALL be one byte per 9 cycles (accept cycle plus 8 shift cycles).
REQ-023 FINISH: SHALL last one cycle. CRC_VALID=1; CRC_VALUE, CRC_RAW and CRC_MATCH reflect the final register. BUSY clears at the end of the cycle; next state is IDLE.
REQ-024 CRC_VALUE, CRC_RAW, CRC_MATCH and BYTE_COUNT SHALL hold their last values until the next frame's first accept.
REQ-025 ABORT in any state SHALL force IDLE on the next edge, clear BUSY, suppress CRC_VALID and leave crc_reg unchanged. ABORT SHALL win over a simultaneous accept or FINISH.
REQ-026 A single-byte frame (DATA_LAST on the first byte) SHALL be legal.
REQ-027 DATA_VALID while DATA_READY=0 SHALL be ignored; the source holds the byte.
REQ-028 A new frame SHALL be acceptable in the cycle immediately after FINISH.

Reset
REQ-029 SHALL, when RSTn=0, immediately force: state IDLE; crc_reg = INIT_VALUE; bit counter 0; BUSY, CRC_VALID and CRC_MATCH = 0; BYTE_COUNT, CRC_VALUE and CRC_RAW = 0.
REQ-030 DATA_READY SHALL be 1 during reset unless ABORT=1.
REQ-031 Reset mid-frame SHALL discard the frame with no CRC_VALID.

Structure
REQ-032 A shared package SHALL hold: state enum (IDLE/SHIFT/FINISH), the CRC32 polynomial, the INIT_VALUE and RESIDUE defaults, and the byte-count width.
REQ-033 One sub-module, crc32_byte_ser, SHALL hold the byte latch, bit counter and LSB-first serializer; the FSM, CRC register and outputs stay in crc32_frame_ctrl.

Verification
REQ-034 Bytes 0x31..0x39 ("123456789"), LAST on 0x39 -> CRC_VALUE = 0xCBF43926; BYTE_COUNT = 9; CRC_VALID a single pulse 9 cycles after the last accept.
REQ-035 Single byte 0x00 with LAST -> CRC_VALUE = 0xD202EF8D; BYTE_COUNT = 1.
REQ-036 "123456789" followed by 0x26, 0x39, 0xF4, 0xCB (LAST on 0xCB) -> CRC_MATCH = 1, CRC_RAW = 0xC704DD7B. The same frame with the last byte 0xCA -> CRC_MATCH = 0.
REQ-037 ABORT during SHIFT of byte 3, then "123456789" -> no CRC_VALID for the aborted frame; the second frame gives 0xCBF43926. ABORT with DATA_VALID in IDLE -> DATA_READY = 0 and the byte is not accepted.
REQ-038 RSTn pulsed low mid-frame -> all outputs at reset values asynchronously; the next "123456789" frame gives 0xCBF43926. Back-to-back frames with no idle gap -> two correct CRC_VALID pulses.
